mcu_spi_packet_master: RTL and testbench
========================================

Name: mcu_spi_packet_master

Overview:
- FPGA-side SPI mode-0 master that reads the 16-byte raw sensor packet from the packet-sending SPI slave using the done/load handshake.
- Used as the loopback and bench partner of the slave, and for FPGA-to-FPGA links.
- Generates sck and shifts in 128 bits MSB-first.
- Checks the 0xAA header, unpacks quaternion/gyro/flags into registered fields, then acknowledges with load.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period (>=2).
- ACK_CYCLES, 2, clk cycles load is held high.
- CLR_TIMEOUT, 255, max clk cycles to wait for done to drop after ack.
- HEADER, 8'hAA, expected byte 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  allow new transfers
- done  in  1  slave data-ready (asynchronous, synchronised internally)
- sdi  in  1  MISO from slave
- sck  out  1  SPI clock, idles low
- sdo  out  1  MOSI, constant 0
- load  out  1  acknowledge pulse to slave
- busy  out  1  high in any state except IDLE
- pkt_valid  out  1  one-cycle strobe, fields updated
- hdr_err  out  1  one-cycle strobe, header mismatch
- quat_w, quat_x, quat_y, quat_z  out  16 signed  quaternion, {MSB,LSB}
- gyro_x, gyro_y, gyro_z  out  16 signed  gyroscope
- quat_valid, gyro_valid  out  1  flag bits 0/1 of byte 15
- pkt_count  out  16  good packets, wraps at 0xFFFF->0
- err_count  out  8  header errors, saturates at 0xFF

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - sck=0, load=0, busy=0, pkt_valid=0, hdr_err=0.
  - All fields, flags and counters = 0.
  - Shift register and bit counter cleared.
- done passes through a 2-flop synchroniser (done_s). sdi is sampled directly; sck is clk-derived.
- FSM states: IDLE, SHIFT, LATCH, ACK, WAIT_CLR.
- IDLE:
  - en && done_s -> SHIFT.
  - Clear divider count and bit_cnt (7 bits) on entry.
  - sck stays low.
- SHIFT:
  - sck low for CLK_DIV cycles, then high for CLK_DIV cycles, repeated 128 times.
  - On the clk edge that drives sck 0->1, shift in sdi: shreg <= {shreg[126:0], sdi}.
  - First bit is valid before the first rising edge.
  - After the 128th high phase, sck returns low -> LATCH.
  - Transfer time: 256*CLK_DIV clk cycles.
  - done_s falling mid-transfer is ignored; all 128 bits are always clocked.
- LATCH (1 cycle):
  - If shreg[127:120]==HEADER: load the fields.
    - quat_w=shreg[119:104], quat_x, quat_y, quat_z follow in order.
    - gyro_x, gyro_y, gyro_z follow.
    - quat_valid=shreg[0], gyro_valid=shreg[1].
    - pkt_valid=1 next cycle; pkt_count++.
  - Else: fields hold, hdr_err=1 next cycle, err_count saturating ++.
  - -> ACK.
- ACK:
  - load=1 for exactly ACK_CYCLES cycles, then load=0 -> WAIT_CLR.
- WAIT_CLR:
  - Wait for done_s==0 or CLR_TIMEOUT cycles, whichever comes first, then -> IDLE.
  - A timeout returns to IDLE silently.
  - If done is still high after a timeout, the next transfer starts immediately (the slave re-asserted).
- en low:
  - Blocks only IDLE->SHIFT.
  - A transfer already in progress completes, including ACK.
- pkt_valid and hdr_err are mutually exclusive, one cycle each.
- Latency from done_s rising to pkt_valid: 256*CLK_DIV + 2 cycles.

Decomposition:
- Package mcu_spi_pkg:
  - PACKET_SIZE=16, PACKET_BITS=128, HEADER_BYTE=8'hAA.
  - Byte offsets for each field.
  - FLAG_QUAT_BIT=0, FLAG_GYRO_BIT=1.
  - State enum typedef.
- Shared with the slave so both ends of the link agree on packet layout.
- One sub-module, spi_sck_gen:
  - Takes run and CLK_DIV.
  - Outputs sck, a rise strobe and a last-edge strobe (after 128 cycles).

Test Plan:
- Reset/idle: rst_n low mid-SHIFT (bit 40) -> sck=0, load=0, busy=0 and fields 0 within the same cycle. After release, no activity while done=0.
- Good packet: slave model with quat w/x/y/z=0x4000/0xC000/0x0001/0x7FFF, gyro 0x0123/0xFEDC/0x8000, flags=0x03 -> fields match, quat_valid=gyro_valid=1, one pkt_valid, pkt_count=1, load high exactly 2 cycles.
- Header error: byte0=0x55 -> hdr_err pulse, fields unchanged from the previous packet, err_count=1, load still pulsed.
- Handshake: done held high 300 cycles after ack -> timeout. Then a second transfer starts; no extra load pulses beyond one per packet.
- en gating: en=0 with done=1 -> no sck edges. Raise en -> transfer starts 1 cycle later. Drop en mid-SHIFT -> 128 sck rises still occur.
- Counters: force pkt_count to 0xFFFF, send a good packet -> 0x0000. Force err_count to 0xFF, send a bad header -> stays 0xFF.

Source files
------------

// File: rtl/mcu_spi_pkg.sv
// Packet layout shared by both ends of the SPI sensor link, plus the master FSM state type.
package mcu_spi_pkg;

    localparam int unsigned PACKET_SIZE = 16;
    localparam int unsigned PACKET_BITS = PACKET_SIZE * 8;
    localparam int unsigned BIT_CNT_W   = $clog2(PACKET_BITS);
    localparam int unsigned WORD_W      = 16;
    localparam logic [7:0]  HEADER_BYTE = 8'hAA;

    localparam int unsigned OFS_HEADER = 0;
    localparam int unsigned OFS_QUAT_W = 1;
    localparam int unsigned OFS_QUAT_X = 3;
    localparam int unsigned OFS_QUAT_Y = 5;
    localparam int unsigned OFS_QUAT_Z = 7;
    localparam int unsigned OFS_GYRO_X = 9;
    localparam int unsigned OFS_GYRO_Y = 11;
    localparam int unsigned OFS_GYRO_Z = 13;
    localparam int unsigned OFS_FLAGS  = 15;

    localparam int unsigned FLAG_QUAT_BIT = 0;
    localparam int unsigned FLAG_GYRO_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_ACK,
        ST_WAIT_CLR
    } state_t;

    typedef logic [PACKET_BITS-1:0] packet_t;

    typedef struct packed {
        logic signed [WORD_W-1:0] quat_w;
        logic signed [WORD_W-1:0] quat_x;
        logic signed [WORD_W-1:0] quat_y;
        logic signed [WORD_W-1:0] quat_z;
        logic signed [WORD_W-1:0] gyro_x;
        logic signed [WORD_W-1:0] gyro_y;
        logic signed [WORD_W-1:0] gyro_z;
        logic                     quat_valid;
        logic                     gyro_valid;
    } fields_t;

    // Byte 0 is the first byte on the wire and lands in the MSBs of the packet.
    function automatic logic [7:0] pkt_byte(input packet_t pkt, input int unsigned ofs);
        return 8'(pkt >> (8 * (PACKET_SIZE - 1 - ofs)));
    endfunction

    function automatic logic [WORD_W-1:0] pkt_word(input packet_t pkt, input int unsigned ofs);
        return {pkt_byte(pkt, ofs), pkt_byte(pkt, ofs + 1)};
    endfunction

    function automatic fields_t unpack_fields(input packet_t pkt);
        fields_t    f;
        logic [7:0] flags;
        flags        = pkt_byte(pkt, OFS_FLAGS);
        f.quat_w     = pkt_word(pkt, OFS_QUAT_W);
        f.quat_x     = pkt_word(pkt, OFS_QUAT_X);
        f.quat_y     = pkt_word(pkt, OFS_QUAT_Y);
        f.quat_z     = pkt_word(pkt, OFS_QUAT_Z);
        f.gyro_x     = pkt_word(pkt, OFS_GYRO_X);
        f.gyro_y     = pkt_word(pkt, OFS_GYRO_Y);
        f.gyro_z     = pkt_word(pkt, OFS_GYRO_Z);
        f.quat_valid = flags[FLAG_QUAT_BIT];
        f.gyro_valid = flags[FLAG_GYRO_BIT];
        return f;
    endfunction

endpackage

// File: rtl/mcu_spi_packet_master_if.sv
// SPI link, handshake and decoded-packet signals of the packet master.
interface mcu_spi_packet_master_if;
    import mcu_spi_pkg::*;

    logic                     en;
    logic                     done;
    logic                     sdi;
    logic                     sck;
    logic                     sdo;
    logic                     load;
    logic                     busy;
    logic                     pkt_valid;
    logic                     hdr_err;
    logic signed [WORD_W-1:0] quat_w;
    logic signed [WORD_W-1:0] quat_x;
    logic signed [WORD_W-1:0] quat_y;
    logic signed [WORD_W-1:0] quat_z;
    logic signed [WORD_W-1:0] gyro_x;
    logic signed [WORD_W-1:0] gyro_y;
    logic signed [WORD_W-1:0] gyro_z;
    logic                     quat_valid;
    logic                     gyro_valid;
    logic [15:0]              pkt_count;
    logic [7:0]               err_count;

    modport master (
        input  en, done, sdi,
        output sck, sdo, load, busy, pkt_valid, hdr_err,
               quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z,
               quat_valid, gyro_valid, pkt_count, err_count
    );

    modport slave (
        output en, done, sdi,
        input  sck, sdo, load, busy, pkt_valid, hdr_err,
               quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z,
               quat_valid, gyro_valid, pkt_count, err_count
    );

endinterface

// File: rtl/mcu_spi_packet_master_sck_gen.sv
// Mode-0 SPI clock generator: low half first, one packet worth of sck periods while run is high.
module spi_sck_gen
    import mcu_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_sck,
    output logic o_rise_c,
    output logic o_last_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]     r_div;
    logic [BIT_CNT_W-1:0] r_bit;
    logic                 r_sck;
    logic                 w_half_end;

    assign w_half_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign o_rise_c   = i_run && w_half_end && !r_sck;
    assign o_last_c   = i_run && w_half_end && r_sck && (r_bit == BIT_CNT_W'(PACKET_BITS - 1));
    assign o_sck      = r_sck;

    // Counters rest at zero whenever run is low so every transfer starts on a clean low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_bit <= '0;
            r_sck <= 1'b0;
        end else if (!i_run) begin
            r_div <= '0;
            r_bit <= '0;
            r_sck <= 1'b0;
        end else if (w_half_end) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (r_sck) begin
                r_bit <= r_bit + BIT_CNT_W'(1);
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/mcu_spi_packet_master.sv
// SPI mode-0 master that pulls a 16-byte sensor packet, checks its header, unpacks it and acks the slave.
module mcu_spi_packet_master
    import mcu_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned ACK_CYCLES  = 2,
    parameter int unsigned CLR_TIMEOUT = 255,
    parameter logic [7:0]  HEADER      = HEADER_BYTE
) (
    input logic                     clk,
    input logic                     rst_n,
    mcu_spi_packet_master_if.master bus
);

    localparam int unsigned ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam int unsigned CLR_W = (CLR_TIMEOUT > 1) ? $clog2(CLR_TIMEOUT) : 1;

    state_t           r_state;
    logic             r_done_meta;
    logic             r_done_s;
    packet_t          r_shreg;
    logic [ACK_W-1:0] r_ack_cnt;
    logic [CLR_W-1:0] r_clr_cnt;
    logic             r_load;
    logic             r_busy;
    logic             r_pkt_valid;
    logic             r_hdr_err;
    fields_t          r_fields;
    logic [15:0]      r_pkt_count;
    logic [7:0]       r_err_count;

    logic             w_run;
    logic             w_sck;
    logic             w_rise;
    logic             w_last;

    assign w_run = (r_state == ST_SHIFT);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_run    (w_run),
        .o_sck    (w_sck),
        .o_rise_c (w_rise),
        .o_last_c (w_last)
    );

    // done comes from another clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_meta <= 1'b0;
            r_done_s    <= 1'b0;
        end else begin
            r_done_meta <= bus.done;
            r_done_s    <= r_done_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_ack_cnt   <= '0;
            r_clr_cnt   <= '0;
            r_load      <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_hdr_err   <= 1'b0;
            r_fields    <= '0;
            r_pkt_count <= '0;
            r_err_count <= '0;
        end else begin
            r_pkt_valid <= 1'b0;
            r_hdr_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.en && r_done_s) begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                // done_s is deliberately ignored here: a started packet is always clocked in full.
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_shreg <= {r_shreg[PACKET_BITS-2:0], bus.sdi};
                    end
                    if (w_last) begin
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (pkt_byte(r_shreg, OFS_HEADER) == HEADER) begin
                        r_fields    <= unpack_fields(r_shreg);
                        r_pkt_valid <= 1'b1;
                        r_pkt_count <= r_pkt_count + 16'd1;
                    end else begin
                        r_hdr_err <= 1'b1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                    end
                    r_load    <= 1'b1;
                    r_ack_cnt <= '0;
                    r_state   <= ST_ACK;
                end
                ST_ACK: begin
                    if (r_ack_cnt == ACK_W'(ACK_CYCLES - 1)) begin
                        r_load    <= 1'b0;
                        r_clr_cnt <= '0;
                        r_state   <= ST_WAIT_CLR;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + ACK_W'(1);
                    end
                end
                // A slave that never drops done is abandoned after the timeout and re-served from IDLE.
                ST_WAIT_CLR: begin
                    if (!r_done_s || (r_clr_cnt == CLR_W'(CLR_TIMEOUT - 1))) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CLR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_load  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sck        = w_sck;
    assign bus.sdo        = 1'b0;
    assign bus.load       = r_load;
    assign bus.busy       = r_busy;
    assign bus.pkt_valid  = r_pkt_valid;
    assign bus.hdr_err    = r_hdr_err;
    assign bus.quat_w     = r_fields.quat_w;
    assign bus.quat_x     = r_fields.quat_x;
    assign bus.quat_y     = r_fields.quat_y;
    assign bus.quat_z     = r_fields.quat_z;
    assign bus.gyro_x     = r_fields.gyro_x;
    assign bus.gyro_y     = r_fields.gyro_y;
    assign bus.gyro_z     = r_fields.gyro_z;
    assign bus.quat_valid = r_fields.quat_valid;
    assign bus.gyro_valid = r_fields.gyro_valid;
    assign bus.pkt_count  = r_pkt_count;
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_mcu_spi_packet_master.sv
// Bench for mcu_spi_packet_master: behavioural slave, byte-level packet model, directed and random packets.
module tb_mcu_spi_packet_master;

    localparam int unsigned CLK_DIV  = 4;
    localparam int          LAT_IDLE = 2 + 256 * CLK_DIV + 2;
    localparam int          LAT_BACK = 256 * CLK_DIV + 2;
    localparam int          BUDGET   = 4000;

    typedef struct packed {
        logic [127:0]      pkt;
        logic              good;
        logic [6:0][15:0]  f;
        logic              qv;
        logic              gv;
        logic [15:0]       pc;
        logic [7:0]        ec;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mcu_spi_packet_master_if bus ();

    mcu_spi_packet_master #(
        .CLK_DIV     (CLK_DIV),
        .ACK_CYCLES  (2),
        .CLR_TIMEOUT (255),
        .HEADER      (8'hAA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model: bit k of the packet (MSB first) is presented once k sck rises have happened.
    int unsigned  n_rise  = 0;
    int unsigned  tx_base = 0;
    logic [127:0] tx_pkt  = '0;
    logic [6:0]   w_idx;
    always @(posedge bus.sck) n_rise <= n_rise + 1;
    assign w_idx   = 7'(127 - int'(n_rise - tx_base));
    assign bus.sdi = tx_pkt[w_idx];

    logic [6:0][15:0] w_dut_f;
    assign w_dut_f = {bus.gyro_z, bus.gyro_y, bus.gyro_x, bus.quat_z, bus.quat_y, bus.quat_x, bus.quat_w};

    logic [6:0][15:0] m_f  = '0;
    logic             m_qv = 1'b0;
    logic             m_gv = 1'b0;
    int               m_pc = 0;
    int               m_ec = 0;

    int x_lat, x_nv, x_ne, x_nl, x_rs, x_cw;
    bit x_ok;

    function automatic logic [6:0][15:0] mkf(input logic [15:0] qw, qx, qy, qz, gx, gy, gz);
        return {gz, gy, gx, qz, qy, qx, qw};
    endfunction

    function automatic logic [127:0] mkp(input logic [7:0] hdr, input logic [6:0][15:0] f, input logic [7:0] flg);
        return {hdr, f[0], f[1], f[2], f[3], f[4], f[5], f[6], flg};
    endfunction

    function automatic vec_t mkv(input logic [127:0] p, input logic g, input logic [6:0][15:0] f,
                                 input logic qv, input logic gv, input logic [15:0] pc, input logic [7:0] ec);
        vec_t v;
        v.pkt = p; v.good = g; v.f = f; v.qv = qv; v.gv = gv; v.pc = pc; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: decode the packet byte by byte and update the expected register file.
    task automatic model_apply(input logic [127:0] p);
        logic [7:0] b [16];
        for (int i = 0; i < 16; i++) b[i] = 8'(p >> (8 * (15 - i)));
        if (b[0] == 8'hAA) begin
            for (int k = 0; k < 7; k++) m_f[k] = {b[1 + 2 * k], b[2 + 2 * k]};
            m_qv = b[15][0];
            m_gv = b[15][1];
            m_pc = (m_pc + 1) % 65536;
        end else begin
            m_ec = (m_ec < 255) ? m_ec + 1 : 255;
        end
    endtask

    // One packet exchange, called at a negedge. drop_done mimics a slave that clears done on load.
    task automatic xfer(input logic [127:0] p, input bit drop_done, input int en_drop_at);
        int load_fall;
        tx_pkt = p;
        tx_base = n_rise;
        x_lat = -1; x_nv = 0; x_ne = 0; x_nl = 0; x_cw = -1; x_ok = 1'b0;
        load_fall = -1;
        bus.done = 1'b1;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            if (cyc == en_drop_at) bus.en = 1'b0;
            if (bus.pkt_valid) begin x_nv++; if (x_lat < 0) x_lat = cyc; end
            if (bus.hdr_err)   begin x_ne++; if (x_lat < 0) x_lat = cyc; end
            if (bus.load) begin
                x_nl++;
                if (drop_done) bus.done = 1'b0;
            end else if (x_nl > 0 && load_fall < 0) begin
                load_fall = cyc;
            end
            if (x_nl > 0 && !bus.busy) begin
                x_ok = 1'b1;
                x_cw = cyc - load_fall;
                break;
            end
        end
        x_rs = int'(n_rise - tx_base);
    endtask

    task automatic chk_xfer(input string tag, input bit good);
        chk({tag, ".complete"}, 16'(x_ok), 16'd1);
        chk({tag, ".pkt_valid"}, 16'(x_nv), good ? 16'd1 : 16'd0);
        chk({tag, ".hdr_err"}, 16'(x_ne), good ? 16'd0 : 16'd1);
        chk({tag, ".load_cycles"}, 16'(x_nl), 16'd2);
        chk({tag, ".sck_rises"}, 16'(x_rs), 16'd128);
    endtask

    task automatic chk_model(input string tag);
        for (int k = 0; k < 7; k++) chk($sformatf("%s.field%0d", tag, k), w_dut_f[k], m_f[k]);
        chk({tag, ".quat_valid"}, 16'(bus.quat_valid), 16'(m_qv));
        chk({tag, ".gyro_valid"}, 16'(bus.gyro_valid), 16'(m_gv));
        chk({tag, ".pkt_count"}, bus.pkt_count, 16'(m_pc));
        chk({tag, ".err_count"}, 16'(bus.err_count), 16'(m_ec));
    endtask

    vec_t vt [4];

    initial begin
        logic [6:0][15:0] w0, w1, w2, w3;
        logic [127:0]     pg, pb;
        int unsigned      base;
        bit               reached;

        w0 = mkf(16'h4000, 16'hC000, 16'h0001, 16'h7FFF, 16'h0123, 16'hFEDC, 16'h8000);
        w1 = mkf(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777);
        w2 = mkf(16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0000);
        w3 = mkf(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0, 16'hAAAA);
        vt[0] = mkv(mkp(8'hAA, w0, 8'h03), 1'b1, w0, 1'b1, 1'b1, 16'd1, 8'd0);
        vt[1] = mkv(mkp(8'h55, w1, 8'h00), 1'b0, w0, 1'b1, 1'b1, 16'd1, 8'd1);
        vt[2] = mkv(mkp(8'hAA, w2, 8'h02), 1'b1, w2, 1'b0, 1'b1, 16'd2, 8'd1);
        vt[3] = mkv(mkp(8'hAA, w3, 8'hFD), 1'b1, w3, 1'b1, 1'b0, 16'd3, 8'd1);
        pg = mkp(8'hAA, w3, 8'h03);
        pb = mkp(8'h3C, w0, 8'h00);

        bus.en   = 1'b0;
        bus.done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.sck", 16'(bus.sck), 16'd0);
        chk("reset.busy", 16'(bus.busy), 16'd0);
        chk("reset.load", 16'(bus.load), 16'd0);
        chk_model("reset");
        rst_n  = 1'b1;
        bus.en = 1'b1;
        base   = n_rise;
        repeat (20) @(negedge clk);
        chk("idle.no_sck", 16'(n_rise - base), 16'd0);
        chk("idle.busy", 16'(bus.busy), 16'd0);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            xfer(vt[i].pkt, 1'b1, 0);
            model_apply(vt[i].pkt);
            chk_xfer($sformatf("vec%0d", i), vt[i].good);
            chk($sformatf("vec%0d.latency", i), 16'(x_lat), 16'(LAT_IDLE));
            for (int k = 0; k < 7; k++) chk($sformatf("vec%0d.field%0d", i, k), w_dut_f[k], vt[i].f[k]);
            chk($sformatf("vec%0d.quat_valid", i), 16'(bus.quat_valid), 16'(vt[i].qv));
            chk($sformatf("vec%0d.gyro_valid", i), 16'(bus.gyro_valid), 16'(vt[i].gv));
            chk($sformatf("vec%0d.pkt_count", i), bus.pkt_count, vt[i].pc);
            chk($sformatf("vec%0d.err_count", i), 16'(bus.err_count), 16'(vt[i].ec));
            chk($sformatf("vec%0d.sdo", i), 16'(bus.sdo), 16'd0);
        end

        // Random packets against the byte-level model
        for (int r = 0; r < 8; r++) begin
            logic [7:0]   b [16];
            logic [127:0] p;
            for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
            b[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hAA;
            p = '0;
            for (int i = 0; i < 16; i++) p = {p[119:0], b[i]};
            xfer(p, 1'b1, 0);
            model_apply(p);
            chk_xfer($sformatf("rnd%0d", r), b[0] == 8'hAA);
            chk($sformatf("rnd%0d.latency", r), 16'(x_lat), 16'(LAT_IDLE));
            chk_model($sformatf("rnd%0d", r));
        end

        // done stuck high: timeout, then the next transfer starts straight away
        xfer(pg, 1'b0, 0);
        model_apply(pg);
        chk_xfer("timeout", 1'b1);
        chk("timeout.clr_wait", 16'(x_cw), 16'd255);
        xfer(pb, 1'b1, 0);
        model_apply(pb);
        chk_xfer("restart", 1'b0);
        chk("restart.latency", 16'(x_lat), 16'(LAT_BACK));
        chk_model("restart");

        // en gating
        @(negedge clk);
        bus.en   = 1'b0;
        tx_pkt   = pg;
        tx_base  = n_rise;
        bus.done = 1'b1;
        repeat (40) @(negedge clk);
        chk("en_low.no_sck", 16'(n_rise - tx_base), 16'd0);
        chk("en_low.busy", 16'(bus.busy), 16'd0);
        bus.en = 1'b1;
        @(negedge clk);
        chk("en_rise.busy", 16'(bus.busy), 16'd1);
        xfer(pg, 1'b1, 300);
        model_apply(pg);
        chk_xfer("en_drop", 1'b1);
        chk("en_drop.en_low", 16'(bus.en), 16'd0);
        chk_model("en_drop");
        bus.en = 1'b1;

        // Counter limits
        @(negedge clk);
        force dut.r_err_count = 8'hFF;
        @(negedge clk);
        release dut.r_err_count;
        m_ec = 255;
        xfer(pb, 1'b1, 0);
        model_apply(pb);
        chk_xfer("err_sat", 1'b0);
        chk_model("err_sat");
        @(negedge clk);
        force dut.r_pkt_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_pkt_count;
        m_pc = 65535;
        xfer(pg, 1'b1, 0);
        model_apply(pg);
        chk_xfer("pkt_wrap", 1'b1);
        chk_model("pkt_wrap");
        xfer(mkp(8'hAA, w0, 8'h01), 1'b1, 0);
        model_apply(mkp(8'hAA, w0, 8'h01));
        chk_xfer("post_wrap", 1'b1);
        chk_model("post_wrap");

        // Asynchronous reset in the middle of a transfer
        @(negedge clk);
        tx_pkt   = pg;
        tx_base  = n_rise;
        bus.done = 1'b1;
        reached  = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (n_rise - tx_base >= 40) begin reached = 1'b1; break; end
        end
        chk("rst_mid.reached_bit40", 16'(reached), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        m_f = '0; m_qv = 1'b0; m_gv = 1'b0; m_pc = 0; m_ec = 0;
        chk("rst_mid.sck", 16'(bus.sck), 16'd0);
        chk("rst_mid.load", 16'(bus.load), 16'd0);
        chk("rst_mid.busy", 16'(bus.busy), 16'd0);
        chk("rst_mid.pkt_valid", 16'(bus.pkt_valid), 16'd0);
        chk("rst_mid.hdr_err", 16'(bus.hdr_err), 16'd0);
        chk_model("rst_mid");
        bus.done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = n_rise;
        repeat (50) @(negedge clk);
        chk("rst_after.no_sck", 16'(n_rise - base), 16'd0);
        chk("rst_after.busy", 16'(bus.busy), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
